// File: rtl/cmd_cntrl.sv
// Transit command controller: consumes UART commands and barcode IDs, tracks
// the destination station, drives in_transit/go and the obstruction buzzer.
module cmd_cntrl #(
    parameter int BUZZ_DIV = 6250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] cmd,
    input  logic       cmd_rdy,
    output logic       clr_cmd_rdy,
    input  logic [7:0] ID,
    input  logic       ID_vld,
    output logic       clr_ID_vld,
    input  logic       OK2Move,
    output logic       in_transit,
    output logic       go,
    output logic       buzz,
    output logic       buzz_n
);

    typedef enum logic {
        IDLE    = 1'b0,
        TRANSIT = 1'b1
    } state_t;

    localparam logic [1:0]  OP_STOP = 2'b00;
    localparam logic [1:0]  OP_GO   = 2'b01;
    localparam logic [12:0] CNT_MAX = 13'(BUZZ_DIV - 1);

    state_t      state_reg, state_next;
    logic [5:0]  dest_reg, dest_next;
    logic [12:0] cnt_reg, cnt_next;
    logic        buzz_reg, buzz_next;

    logic [5:0]  id_bit_eq;
    logic        id_match;
    logic        go_cmd;
    logic        stop_cmd;
    logic        obstructed;

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_id_cmp
            assign id_bit_eq[gi] = ~(ID[gi] ^ dest_reg[gi]);
        end
    endgenerate

    // A barcode only counts as arrival when its upper bits are clear.
    assign id_match   = (ID[7:6] == 2'b00) && (&id_bit_eq);
    assign go_cmd     = (cmd[7:6] == OP_GO) && (cmd[5:0] != 6'd0);
    assign stop_cmd   = (cmd[7:6] == OP_STOP);
    assign obstructed = (state_reg == TRANSIT) && !OK2Move;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            dest_reg  <= 6'd0;
            cnt_reg   <= 13'd0;
            buzz_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            dest_reg  <= dest_next;
            cnt_reg   <= cnt_next;
            buzz_reg  <= buzz_next;
        end
    end

    // Commands take priority; a pending ID waits a cycle and is then
    // compared against whatever dest the command left behind.
    always_comb begin
        state_next = state_reg;
        dest_next  = dest_reg;
        if (cmd_rdy) begin
            if (go_cmd) begin
                dest_next  = cmd[5:0];
                state_next = TRANSIT;
            end else if (stop_cmd) begin
                state_next = IDLE;
            end
        end else if (ID_vld && (state_reg == TRANSIT) && id_match) begin
            state_next = IDLE;
        end
    end

    always_comb begin
        cnt_next  = 13'd0;
        buzz_next = 1'b0;
        if (obstructed) begin
            if (cnt_reg >= CNT_MAX) begin
                cnt_next  = 13'd0;
                buzz_next = ~buzz_reg;
            end else begin
                cnt_next  = cnt_reg + 13'd1;
                buzz_next = buzz_reg;
            end
        end
    end

    always_comb begin
        in_transit  = (state_reg == TRANSIT);
        clr_cmd_rdy = cmd_rdy & ~rst;
        clr_ID_vld  = ID_vld & ~cmd_rdy & ~rst;
    end

    assign go     = in_transit & OK2Move;
    assign buzz   = buzz_reg;
    assign buzz_n = ~buzz_reg;

endmodule

// File: doc/cmd_cntrl.md
# cmd_cntrl

Transit command controller for the Follower robot. It takes decoded Bluetooth commands from the UART receiver and station IDs from the barcode reader, and holds the destination station. It drives `in_transit` and `go` to the motion/PID path and generates the piezo buzzer drive while the bot is obstructed. It sits between the UART/barcode front ends and the motor controller.

## Interface
Parameters:
- `BUZZ_DIV`, default 6250: clk cycles per buzzer half-period (4 kHz at 50 MHz). Legal range 2..8191.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  synchronous, active-high reset. One clock, `clk`; reset is synchronous and active-high.
- `cmd`  in  8  UART command byte. `[7:6]`=opcode (00 STOP, 01 GO); `[5:0]`=destination station.
- `cmd_rdy`  in  1  UART byte valid. Level signal, held until cleared.
- `clr_cmd_rdy`  out  1  one-cycle pulse that consumes `cmd_rdy`.
- `ID`  in  8  barcode station ID. `[7:6]` must be 00 for a valid ID.
- `ID_vld`  in  1  barcode ID valid. Level signal, held until cleared.
- `clr_ID_vld`  out  1  one-cycle pulse that consumes `ID_vld`.
- `OK2Move`  in  1  proximity sensor; 1 means the path is clear.
- `in_transit`  out  1  bot is travelling to a destination.
- `go`  out  1  motor enable, equal to `in_transit & OK2Move`.
- `buzz`  out  1  piezo drive.
- `buzz_n`  out  1  complement of `buzz`.

## Operation
- Two-state FSM: IDLE and TRANSIT. `in_transit` is 1 exactly when the state is TRANSIT.
- Registers:
  - `dest[5:0]`, the captured destination.
  - Buzzer divider counter, 13 bits.
  - `buzz` flop.
- IDLE:
  - `cmd_rdy` with opcode GO and `cmd[5:0]` != 0: load `dest`, pulse `clr_cmd_rdy`, go to TRANSIT.
  - `cmd_rdy` with any other opcode, or GO to station 0: pulse `clr_cmd_rdy`, stay in IDLE.
  - `ID_vld`: pulse `clr_ID_vld`, stay in IDLE. A stale barcode is discarded.
- TRANSIT:
  - `cmd_rdy` with GO and nonzero dest: reload `dest` (override), pulse `clr_cmd_rdy`, stay in TRANSIT.
  - `cmd_rdy` with STOP: pulse `clr_cmd_rdy`, go to IDLE.
  - `cmd_rdy` with any other opcode: pulse `clr_cmd_rdy`, no change.
  - `ID_vld` and no `cmd_rdy`: pulse `clr_ID_vld`.
    - If `ID[7:6]==00` and `ID[5:0]==dest`: go to IDLE.
    - Otherwise stay in TRANSIT.
- Priority: when `cmd_rdy` and `ID_vld` are both high, only the command is processed that cycle. `ID_vld` stays pending and is compared on the next cycle against the updated `dest`.
- Buzzer:
  - While `in_transit & ~OK2Move`: the counter counts 0..BUZZ_DIV-1. On wrap to 0, `buzz` toggles.
  - Otherwise: the counter is held at 0 and `buzz`=0.
  - `buzz_n` = `~buzz` at all times.
- `go` is combinational from the registered `in_transit` and the input `OK2Move`.

## Timing
- Reset values:
  - State IDLE, `dest`=0, counter=0.
  - `in_transit`=0, `go`=0, `buzz`=0, `buzz_n`=1, `clr_cmd_rdy`=0, `clr_ID_vld`=0.
- `clr_cmd_rdy` and `clr_ID_vld` are Mealy outputs, high in the same cycle the input is sampled. The upstream flag drops at the next edge. The controller never pulses a clear twice for one flag level.
- `in_transit` changes on the edge after the qualifying `cmd_rdy`/`ID_vld` cycle, i.e. 1-cycle latency.
- `go` follows `OK2Move` combinationally while in TRANSIT.
- First `buzz` rising edge occurs BUZZ_DIV cycles after obstruction begins. Period is 2·BUZZ_DIV.
- Obstruction clearing mid-half-period resets the counter and forces `buzz`=0 on the next edge. A new obstruction restarts the divider from 0.
- `rst` asserted mid-transit returns all state to reset values on the next edge, regardless of other inputs.

## Test plan
1. Reset, then `cmd`=0x41 with `cmd_rdy` → `clr_cmd_rdy` pulses for 1 cycle. `in_transit`=1 next cycle, `go`=1 with `OK2Move`=1, `dest`=1.
2. In transit to 1, send `cmd`=0x43, then `ID`=0x01 → `in_transit` stays 1 and `clr_ID_vld` pulses. Then `ID`=0x03 → `in_transit`=0 one cycle later.
3. In transit to 5, `ID`=0x45 (bad upper bits) → stays in TRANSIT. `cmd`=0x00 (STOP) → IDLE. In IDLE, `ID`=0x05 → cleared, remains IDLE.
4. `cmd_rdy` (0x43) and `ID_vld` (0x03) asserted together while going to 1 → first cycle only `clr_cmd_rdy` pulses. Next cycle `clr_ID_vld` pulses and the bot stops.
5. With `BUZZ_DIV`=8: in transit, drop `OK2Move` → `go`=0 immediately, `buzz` rises after 8 cycles, period 16, `buzz_n`=~`buzz`. Raise `OK2Move` → `buzz`=0 next edge, `go`=1.
6. Assert `rst` during transit while buzzing → next edge: `in_transit`=0, `buzz`=0, `buzz_n`=1. GO to station 0 (`cmd`=0x40) → cleared, stays IDLE.
